// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the half-precision adder normalization stage:
// field widths, the packed FP16 result type and the normalizer state encoding.
//
// Mantissa-sum layout used throughout (MAN_W+4 bits):
//   [MAN_W+3] carry, [MAN_W+2] hidden, [MAN_W+1:2] fraction,
//   [1] guard, [0] sticky
// ---------------------------------------------------------------------------
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int BIAS     = 15;
  localparam int MAN_IN_W = MAN_W + 4;

  // All-ones exponent: the Inf/NaN code.
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  localparam int CARRY_BIT  = MAN_W + 3;
  localparam int HIDDEN_BIT = MAN_W + 2;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHIFT,
    FINAL,
    ROUND,
    DONE
  } norm_state_e;

endpackage

// File: rtl/fp16_normalizer_exp_step.sv
// ---------------------------------------------------------------------------
// exp_step
// W-bit ripple incrementer/decrementer for the exponent field. A single
// instance serves the carry increment, the per-shift decrement and the
// rounding increment, since those never occur in the same cycle.
//
// Ports:
//   a    in  W  operand
//   inc  in  1  1 = a+1, 0 = a-1 (both modulo 2^W)
//   y    out W  result
// ---------------------------------------------------------------------------
module exp_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic         inc,
  output logic [W-1:0] y
);

  // chain[gi] is the carry (increment) or borrow (decrement) into bit gi.
  logic [W-1:0] chain;

  assign chain[0] = 1'b1;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign y[gi] = a[gi] ^ chain[gi];
    if (gi < W - 1) begin : g_prop
      // Increment propagates through ones, decrement through zeros.
      assign chain[gi+1] = (inc ? a[gi] : ~a[gi]) & chain[gi];
    end
  end

endmodule

// File: rtl/fp16_normalizer.sv
// ---------------------------------------------------------------------------
// fp16_normalizer
// Post-add normalization stage of the half-precision adder. Takes the raw
// mantissa sum and the larger operand's biased exponent, restores 1.f form
// (one right shift on carry-out, or iterative one-bit left shifts), and
// returns the packed FP16 result with status flags over valid/ready.
//
// Optional feature macro: FP16_NORM_ROUND_EN
//   defined   -> extra ROUND state, round-to-nearest-even
//   undefined -> truncation; guard/sticky only drive out_inexact
//
// Ports:
//   clk           in   1             clock
//   rst_n         in   1             synchronous active-low reset
//   in_valid      in   1             operand valid
//   in_ready      out  1             idle and accepting
//   in_sign       in   1             result sign
//   in_exp        in   EXP_W         biased exponent of larger operand (1..30)
//   in_man        in   MAN_W+4       {carry, hidden, frac, guard, sticky}
//   out_valid     out  1             result valid
//   out_ready     in   1             downstream accepts
//   out_result    out  1+EXP_W+MAN_W packed {sign, exp, frac}
//   out_overflow  out  1             result saturated to +/-Inf
//   out_zero      out  1             mantissa sum was zero
//   out_inexact   out  1             guard|sticky nonzero at final position
// ---------------------------------------------------------------------------
module fp16_normalizer
  import fp16_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic [MAN_IN_W-1:0]      in_man,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1+EXP_W+MAN_W-1:0] out_result,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic                     out_inexact
);

  norm_state_e           state_reg, state_next;
  logic                  sign_reg, sign_next;
  logic [EXP_W-1:0]      exp_reg, exp_next;
  logic [MAN_IN_W-1:0]   man_reg, man_next;
  fp16_t                 result_reg, result_next;
  logic                  overflow_reg, overflow_next;
  logic                  zero_reg, zero_next;
  logic                  inexact_reg, inexact_next;
  // Set when CHECK already produced the final word (zero or overflow), so
  // FINAL must not repack it from the mantissa.
  logic                  special_reg, special_next;
`ifdef FP16_NORM_ROUND_EN
  logic                  round_up_reg, round_up_next;
`endif

  logic [MAN_IN_W-1:0]   man_shl;
  logic [MAN_IN_W-1:0]   man_shr;
  logic                  step_inc;
  logic [EXP_W-1:0]      step_y;

  // Left shift brings a zero into the sticky position. Right shift keeps the
  // bit falling off the bottom by folding it into sticky.
  assign man_shl = {man_reg[MAN_IN_W-2:0], 1'b0};
  assign man_shr = {1'b0, man_reg[MAN_IN_W-1:2], man_reg[1] | man_reg[0]};

  // Only SHIFT decrements; CHECK (carry) and ROUND increment.
  assign step_inc = (state_reg != SHIFT);

  exp_step #(
    .W(EXP_W)
  ) u_exp_step (
    .a  (exp_reg),
    .inc(step_inc),
    .y  (step_y)
  );

  always_comb begin
    state_next    = state_reg;
    sign_next     = sign_reg;
    exp_next      = exp_reg;
    man_next      = man_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    zero_next     = zero_reg;
    inexact_next  = inexact_reg;
    special_next  = special_reg;
`ifdef FP16_NORM_ROUND_EN
    round_up_next = round_up_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next     = in_sign;
          exp_next      = in_exp;
          man_next      = in_man;
          result_next   = '0;
          overflow_next = 1'b0;
          zero_next     = 1'b0;
          inexact_next  = 1'b0;
          special_next  = 1'b0;
          state_next    = CHECK;
        end
      end

      CHECK: begin
        // Zero and overflow still pass through FINAL so that every path
        // without left shifts has the same accept-to-valid latency.
        state_next = FINAL;
        if (man_reg == '0) begin
          zero_next    = 1'b1;
          special_next = 1'b1;
          result_next  = '{sign: sign_reg, exp: '0, frac: '0};
        end else if (man_reg[CARRY_BIT]) begin
          man_next = man_shr;
          exp_next = step_y;
          if (step_y == EXP_MAX) begin
            overflow_next = 1'b1;
            special_next  = 1'b1;
            result_next   = '{sign: sign_reg, exp: EXP_MAX, frac: '0};
          end
        end else if (!man_reg[HIDDEN_BIT] && (exp_reg > EXP_ONE)) begin
          state_next = SHIFT;
        end
        // hidden=1, or exponent already at the subnormal floor: no shifting.
      end

      SHIFT: begin
        if (!man_reg[HIDDEN_BIT] && (exp_reg > EXP_ONE)) begin
          man_next = man_shl;
          exp_next = step_y;
          // Decide on the post-shift value so no idle cycle is spent in SHIFT.
          if (man_shl[HIDDEN_BIT] || (step_y == EXP_ONE)) begin
            state_next = FINAL;
          end
        end else begin
          state_next = FINAL;
        end
      end

      FINAL: begin
        if (!special_reg) begin
          result_next.sign = sign_reg;
          result_next.exp  = man_reg[HIDDEN_BIT] ? exp_reg : '0;
          result_next.frac = man_reg[MAN_W+1:2];
          inexact_next     = man_reg[1] | man_reg[0];
        end
`ifdef FP16_NORM_ROUND_EN
        // Nearest-even: round up above halfway, or at halfway when odd.
        round_up_next = !special_reg && man_reg[1] && (man_reg[0] || man_reg[2]);
        state_next    = ROUND;
`else
        state_next    = DONE;
`endif
      end

`ifdef FP16_NORM_ROUND_EN
      ROUND: begin
        if (round_up_reg) begin
          if (result_reg.frac == '1) begin
            result_next.frac = '0;
            if (man_reg[HIDDEN_BIT]) begin
              // Carry into the hidden bit of a normal value bumps the exponent.
              if (step_y == EXP_MAX) begin
                overflow_next   = 1'b1;
                result_next.exp = EXP_MAX;
              end else begin
                result_next.exp = step_y;
              end
            end else begin
              // Largest subnormal rounds up to the smallest normal.
              result_next.exp = EXP_ONE;
            end
          end else begin
            result_next.frac = result_reg.frac + MAN_W'(1);
          end
        end
        state_next = DONE;
      end
`endif

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      man_reg      <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      inexact_reg  <= 1'b0;
      special_reg  <= 1'b0;
`ifdef FP16_NORM_ROUND_EN
      round_up_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      sign_reg     <= sign_next;
      exp_reg      <= exp_next;
      man_reg      <= man_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      zero_reg     <= zero_next;
      inexact_reg  <= inexact_next;
      special_reg  <= special_next;
`ifdef FP16_NORM_ROUND_EN
      round_up_reg <= round_up_next;
`endif
    end
  end

  // in_ready is forced low while reset is asserted, even though the state
  // register only clears on the next edge.
  assign in_ready     = rst_n && (state_reg == IDLE);
  assign out_valid    = (state_reg == DONE);
  assign out_result   = result_reg;
  assign out_overflow = overflow_reg;
  assign out_zero     = zero_reg;
  assign out_inexact  = inexact_reg;

endmodule
